fifo_reader: RTL and testbench

FIFO_READER -- requirements
Module: fifo_reader

---
 rtl/fifo_reader.sv | 172 +++++++++++++++++
 tb/tb_fifo_reader.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_reader.sv
// ---------------------------------------------------------------------------
// fifo_reader
//
// Pulls words out of a synchronous FIFO (read data arrives one cycle after
// the pop) and presents them as a valid/ready stream through a 2-entry
// in-order output buffer. A four-state read FSM issues at most one pop every
// four cycles so the FIFO's empty flag has time to settle after each pop.
//
// Parameters
//   DATA_W      width of FIFO read data and stream data (default 8)
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   enable      allow new FIFO reads (buffered data drains regardless)
//   flush       synchronous discard of buffered and in-flight data
//   fifo_empty  FIFO empty flag
//   fifo_rdata  FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en  registered single-cycle pop request
//   m_data      stream data (oldest buffered entry)
//   m_valid     stream valid
//   m_ready     stream ready from the consumer
//   rd_count    (FIFO_READER_CNT_EN only) 16-bit wrapping count of
//               completed output handshakes, cleared by flush
//
// Build option
//   `define FIFO_READER_CNT_EN to add the rd_count output and its counter.
// ---------------------------------------------------------------------------
module fifo_reader #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              flush,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_rdata,
   output logic              fifo_rd_en,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready
`ifdef FIFO_READER_CNT_EN
   ,
   output logic [15:0]       rd_count
`endif
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      READ   = 2'd1,
      CAPT   = 2'd2,
      SETTLE = 2'd3
   } state_t;

   state_t            state_reg;
   state_t            state_next;
   logic              rd_en_reg;
   logic              rd_en_next;

   logic [DATA_W-1:0] buf_reg [2];
   logic              wr_ptr_reg;
   logic              rd_ptr_reg;
   logic [1:0]        occ_reg;

   logic              capture;
   logic              consume;

   // ------------------------------------------------------------------
   // FSM state register; fifo_rd_en is a flop loaded with "next state is
   // READ", so it is high exactly while the FSM sits in READ.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         rd_en_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         rd_en_reg <= rd_en_next;
      end
   end

   // ------------------------------------------------------------------
   // FSM next-state logic. Flush overrides everything and returns to IDLE,
   // which also drops an issued READ/CAPT so its data is never captured.
   // ------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      if (flush) begin
         state_next = IDLE;
      end else begin
         case (state_reg)
            IDLE:    if (enable && !fifo_empty && (occ_reg < 2'd2))
                        state_next = READ;
            READ:    state_next = CAPT;
            CAPT:    state_next = SETTLE;
            SETTLE:  state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // FSM / datapath outputs
   // ------------------------------------------------------------------
   always_comb begin
      rd_en_next = (state_next == READ);
      // FIFO data is on fifo_rdata during CAPT (one cycle after the pop)
      capture    = (state_reg == CAPT) && !flush;
      consume    = m_valid && m_ready && !flush;
   end

   assign fifo_rd_en = rd_en_reg;
   assign m_valid    = (occ_reg != 2'd0);
   assign m_data     = buf_reg[rd_ptr_reg];

   // ------------------------------------------------------------------
   // Output buffer storage, one register per entry
   // ------------------------------------------------------------------
   for (genvar gi = 0; gi < 2; gi++) begin : g_entry
      always_ff @(posedge clk or posedge rst) begin
         if (rst)
            buf_reg[gi] <= '0;
         else if (capture && (wr_ptr_reg == 1'(gi)))
            buf_reg[gi] <= fifo_rdata;
      end
   end

   // ------------------------------------------------------------------
   // Pointers and occupancy. A simultaneous capture and consume moves both
   // pointers and leaves the occupancy unchanged.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
         occ_reg    <= 2'd0;
      end else if (flush) begin
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
         occ_reg    <= 2'd0;
      end else begin
         if (capture)
            wr_ptr_reg <= ~wr_ptr_reg;
         if (consume)
            rd_ptr_reg <= ~rd_ptr_reg;
         case ({capture, consume})
            2'b10:   occ_reg <= occ_reg + 2'd1;
            2'b01:   occ_reg <= occ_reg - 2'd1;
            default: occ_reg <= occ_reg;
         endcase
      end
   end

`ifdef FIFO_READER_CNT_EN
   // ------------------------------------------------------------------
   // Handshake counter, wraps naturally at 16 bits
   // ------------------------------------------------------------------
   logic [15:0] cnt_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt_reg <= 16'd0;
      else if (flush)
         cnt_reg <= 16'd0;
      else if (consume)
         cnt_reg <= cnt_reg + 16'd1;
   end

   assign rd_count = cnt_reg;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// ---------------------------------------------------------------------------
// tb_fifo_reader
//
// Self-checking bench for fifo_reader: a FIFO model feeds the DUT, a
// cycle table covers the single-word and back-pressure cases, hand-written
// sequences cover streaming, flush and mid-read reset, and a randomized
// phase is checked against a reference model that tracks popped words and
// the cycle each becomes deliverable.
// ---------------------------------------------------------------------------
module tb_fifo_reader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic        flush = 1'b0;
   logic        m_ready = 1'b0;
   logic        fifo_clear = 1'b0;
   logic        fifo_empty;
   logic        fifo_rd_en;
   logic        m_valid;
   logic [7:0]  fifo_rdata = 8'h00;
   logic [7:0]  m_data;
`ifdef FIFO_READER_CNT_EN
   logic [15:0] rd_count;
`endif

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   always #5 clk = ~clk;

   fifo_reader #(.DATA_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .flush      (flush),
      .fifo_empty (fifo_empty),
      .fifo_rdata (fifo_rdata),
      .fifo_rd_en (fifo_rd_en),
      .m_data     (m_data),
      .m_valid    (m_valid),
      .m_ready    (m_ready)
`ifdef FIFO_READER_CNT_EN
      ,
      .rd_count   (rd_count)
`endif
   );

   // ---------------- FIFO model: data appears the cycle after a pop -----
   logic [7:0]  fmem [4096];
   logic [11:0] wr_idx = 12'd0;
   logic [11:0] rd_idx = 12'd0;

   assign fifo_empty = (rd_idx == wr_idx);

   always @(posedge clk) begin
      if (fifo_clear)
         rd_idx <= wr_idx;
      else if (fifo_rd_en && !fifo_empty) begin
         fifo_rdata <= fmem[rd_idx];
         rd_idx     <= rd_idx + 12'd1;
      end
   end

   task automatic push(input logic [7:0] d);
      fmem[wr_idx] = d;
      wr_idx = wr_idx + 12'd1;
   endtask

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reset the DUT and empty the FIFO model; returns at the start of
   // cycle 0, the first cycle with rst low.
   task automatic do_reset();
      rst = 1'b1; flush = 1'b0; enable = 1'b0; m_ready = 1'b0;
      fifo_clear = 1'b1;
      @(posedge clk);
      #1;
      check("reset_rd_en", 32'(fifo_rd_en), 32'(0));
      check("reset_m_valid", 32'(m_valid), 32'(0));
      check("reset_m_data", 32'(m_data), 32'(0));
      @(negedge clk);
      rst = 1'b0;
      fifo_clear = 1'b0;
      cyc = 0;
   endtask

   // ---------------- cycle table ----------------------------------------
   typedef struct {
      logic       en;
      logic       rdy;
      logic       exp_rd;
      logic       exp_mv;
      logic [7:0] exp_data;
   } vec_t;

   vec_t vecs [27];

   task automatic setv(input int i, input logic en, input logic rdy,
                       input logic rd, input logic mv, input logic [7:0] d);
      vecs[i].en = en; vecs[i].rdy = rdy; vecs[i].exp_rd = rd;
      vecs[i].exp_mv = mv; vecs[i].exp_data = d;
   endtask

   task automatic run_vecs(input string name, input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         enable  = vecs[i].en;
         m_ready = vecs[i].rdy;
         #1;
         check({name, "_rd_en"}, 32'(fifo_rd_en), 32'(vecs[i].exp_rd));
         check({name, "_m_valid"}, 32'(m_valid), 32'(vecs[i].exp_mv));
         if (vecs[i].exp_mv)
            check({name, "_m_data"}, 32'(m_data), 32'(vecs[i].exp_data));
         @(negedge clk);
      end
   endtask

   // ---------------- reference model for random phase -------------------
   typedef struct {
      logic [7:0] d;
      int         avail;
   } pend_t;

   pend_t pend[$];
   int    last_pulse;
   logic  prev_en;
   logic  prev_flush;

   task automatic rand_cycle(input bit randomize_inputs);
      logic exp_mv;
      if (randomize_inputs) begin
         enable  = ($urandom_range(0, 9) != 0);
         m_ready = 1'($urandom_range(0, 1));
         flush   = ($urandom_range(0, 49) == 0);
         if ($urandom_range(0, 5) == 0)
            push(8'($urandom_range(0, 255)));
      end
      #1;
      if (prev_flush)
         check("rand_rd_after_flush", 32'(fifo_rd_en), 32'(0));
      if (fifo_rd_en) begin
         check("rand_issue_cond", 32'(prev_en && !prev_flush), 32'(1));
         check("rand_spacing_ge4", 32'((cyc - last_pulse) >= 4), 32'(1));
         check("rand_room", 32'(pend.size() < 2), 32'(1));
         check("rand_fifo_nonempty", 32'(fifo_empty), 32'(0));
         pend.push_back('{d: fmem[rd_idx], avail: cyc + 2});
         last_pulse = cyc;
      end
      exp_mv = (pend.size() > 0) && (pend[0].avail <= cyc);
      check("rand_m_valid", 32'(m_valid), 32'(exp_mv));
      if (exp_mv)
         check("rand_m_data", 32'(m_data), 32'(pend[0].d));
      if (flush) begin
         pend.delete();
         last_pulse = -100;
      end else if (exp_mv && m_ready) begin
         void'(pend.pop_front());
      end
      prev_en    = enable;
      prev_flush = flush;
      cyc++;
      @(negedge clk);
   endtask

   // ---------------- main sequence --------------------------------------
   initial begin
      int         pulses;
      bit         done;
      int         first_rd;
      int         first_mv;
      int         budget;
      int         pc[$];
      logic [7:0] outs[$];

      // single word, ready consumer
      for (int i = 0; i <= 6; i++) setv(i, 1, 1, 0, 0, 8'h00);
      setv(1, 1, 1, 1, 0, 8'h00);
      setv(3, 1, 1, 0, 1, 8'hA5);
      // four words, stalled consumer, one handshake at cycle 15
      for (int i = 0; i < 20; i++) setv(7 + i, 1, 0, 0, 1, 8'h01);
      setv(7 + 0, 1, 0, 0, 0, 8'h00);
      setv(7 + 1, 1, 0, 1, 0, 8'h00);
      setv(7 + 2, 1, 0, 0, 0, 8'h00);
      setv(7 + 5, 1, 0, 1, 1, 8'h01);
      setv(7 + 15, 1, 1, 0, 1, 8'h01);
      setv(7 + 16, 1, 0, 0, 1, 8'h02);
      setv(7 + 17, 1, 0, 1, 1, 8'h02);
      setv(7 + 18, 1, 0, 0, 1, 8'h02);
      setv(7 + 19, 1, 0, 0, 1, 8'h02);

      do_reset();
      push(8'hA5);
      run_vecs("single", 0, 6);

      do_reset();
      for (int k = 1; k <= 4; k++) push(8'(k));
      run_vecs("stall", 7, 26);

      // continuous stream
      do_reset();
      for (int k = 0; k < 8; k++) push(8'(8'h10 + k));
      enable = 1'b1; m_ready = 1'b1;
      for (int i = 0; i < 60; i++) begin
         #1;
         if (fifo_rd_en) pc.push_back(i);
         if (m_valid && m_ready) outs.push_back(m_data);
         @(negedge clk);
      end
      check("stream_pulses", 32'(pc.size()), 32'(8));
      for (int k = 0; k + 1 < pc.size(); k++)
         check("stream_gap", 32'(pc[k+1] - pc[k]), 32'(4));
      check("stream_count", 32'(outs.size()), 32'(8));
      for (int k = 0; k < outs.size(); k++)
         check("stream_data", 32'(outs[k]), 32'(8'h10 + k));
`ifdef FIFO_READER_CNT_EN
      #1;
      check("count_after_stream", 32'(rd_count), 32'(8));
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      #1;
      check("count_after_flush", 32'(rd_count), 32'(0));
      @(negedge clk);
`endif

      // flush during CAPT with one entry already buffered
      do_reset();
      push(8'h01); push(8'h02);
      enable = 1'b1; m_ready = 1'b0;
      pulses = 0; done = 1'b0;
      for (int i = 0; i < 30 && !done; i++) begin
         #1;
         if (fifo_rd_en) pulses++;
         if (pulses == 2 && fifo_rd_en) begin
            @(negedge clk);
            flush = 1'b1;
            #1;
            check("flush_buffered_before", 32'(m_valid), 32'(1));
            @(negedge clk);
            flush = 1'b0; m_ready = 1'b1;
            #1;
            check("flush_m_valid_next", 32'(m_valid), 32'(0));
            check("flush_rd_en_next", 32'(fifo_rd_en), 32'(0));
            done = 1'b1;
         end
         @(negedge clk);
      end
      check("flush_reached_second_read", 32'(pulses), 32'(2));
      for (int i = 0; i < 12; i++) begin
         #1;
         check("flush_never_delivered", 32'(m_valid), 32'(0));
         @(negedge clk);
      end

      // asynchronous reset while in READ
      do_reset();
      push(8'hA5);
      enable = 1'b1; m_ready = 1'b1;
      @(negedge clk);
      #1;
      check("rst_mid_read_pre", 32'(fifo_rd_en), 32'(1));
      rst = 1'b1;
      #1;
      check("rst_async_rd_en", 32'(fifo_rd_en), 32'(0));
      check("rst_async_m_valid", 32'(m_valid), 32'(0));
      @(negedge clk);
      rst = 1'b0;
      first_rd = -1; first_mv = -1;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (fifo_rd_en && first_rd < 0) first_rd = i;
         if (m_valid && first_mv < 0) begin
            first_mv = i;
            check("rst_retry_data", 32'(m_data), 32'(8'hA5));
         end
         @(negedge clk);
      end
      check("rst_retry_rd_cycle", 32'(first_rd), 32'(1));
      check("rst_retry_mv_cycle", 32'(first_mv), 32'(3));

      // randomized traffic
      do_reset();
      pend.delete();
      last_pulse = -100; prev_en = 1'b0; prev_flush = 1'b0;
      for (int i = 0; i < 3000; i++) rand_cycle(1'b1);
      enable = 1'b1; m_ready = 1'b1; flush = 1'b0;
      budget = 4 * int'(wr_idx - rd_idx) + 40;
      for (int i = 0; i < budget && !(fifo_empty && pend.size() == 0); i++)
         rand_cycle(1'b0);
      check("rand_drained_fifo", 32'(fifo_empty), 32'(1));
      check("rand_drained_model", 32'(pend.size()), 32'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
